// File: rtl/dma_write_splitter_if.sv
// Command and data stream bundle for the DMA write splitter.
// slave is the splitter's view; master is the view of whoever drives it.
interface dma_write_splitter_if;
    logic         s_cmd_valid;
    logic         s_cmd_ready;
    logic [63:0]  s_cmd_address;
    logic [31:0]  s_cmd_length;
    logic         s_data_valid;
    logic         s_data_ready;
    logic [511:0] s_data_data;
    logic [63:0]  s_data_keep;
    logic         s_data_last;
    logic         m_cmd_valid;
    logic         m_cmd_ready;
    logic [63:0]  m_cmd_address;
    logic [31:0]  m_cmd_length;
    logic         m_data_valid;
    logic         m_data_ready;
    logic [511:0] m_data_data;
    logic [63:0]  m_data_keep;
    logic         m_data_last;

    modport slave (
        input  s_cmd_valid, s_cmd_address, s_cmd_length,
        output s_cmd_ready,
        input  s_data_valid, s_data_data, s_data_keep, s_data_last,
        output s_data_ready,
        output m_cmd_valid, m_cmd_address, m_cmd_length,
        input  m_cmd_ready,
        output m_data_valid, m_data_data, m_data_keep, m_data_last,
        input  m_data_ready
    );

    modport master (
        output s_cmd_valid, s_cmd_address, s_cmd_length,
        input  s_cmd_ready,
        output s_data_valid, s_data_data, s_data_keep, s_data_last,
        input  s_data_ready,
        input  m_cmd_valid, m_cmd_address, m_cmd_length,
        output m_cmd_ready,
        input  m_data_valid, m_data_data, m_data_keep, m_data_last,
        output m_data_ready
    );
endinterface

// File: rtl/dma_write_splitter.sv
// Splits one DMA write command into chunks bounded by MAX_PAYLOAD and
// BOUNDARY, re-framing the 512-bit data stream with per-chunk last.
module dma_write_splitter #(
    parameter int MAX_PAYLOAD = 512,
    parameter int BOUNDARY    = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    dma_write_splitter_if.slave   bus,
    output logic [31:0]           cmd_count,
    output logic [31:0]           chunk_count,
    output logic                  err_cmd,
    output logic                  err_last
);
    localparam int BW = $clog2(MAX_PAYLOAD / 64) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CMD,
        DATA
    } state_t;

    state_t          r_state;
    logic [63:0]     r_cur_addr;
    logic [31:0]     r_rem;
    logic [31:0]     r_chunk;
    logic [BW-1:0]   r_beats;
    logic [BW-1:0]   r_beat_cnt;
    logic            r_m_cmd_valid;
    logic [31:0]     r_cmd_count;
    logic [31:0]     r_chunk_count;
    logic            r_err_cmd;
    logic            r_err_last;

    logic [63:0]     w_to_bnd;
    logic [31:0]     w_chunk;
    logic [BW-1:0]   w_beats;
    logic            w_cmd_hs;
    logic            w_beat_hs;
    logic            w_final;
    logic            w_last_chunk;
    logic            w_in_data;

    assign w_to_bnd = 64'(BOUNDARY) - (r_cur_addr & 64'(BOUNDARY - 1));

    always_comb begin
        w_chunk = r_rem;
        if (w_chunk > 32'(MAX_PAYLOAD)) w_chunk = 32'(MAX_PAYLOAD);
        if (64'(w_chunk) > w_to_bnd) w_chunk = w_to_bnd[31:0];
    end

    assign w_beats      = BW'((w_chunk >> 6) - 32'd1);
    assign w_in_data    = (r_state == DATA);
    assign w_cmd_hs     = bus.s_cmd_valid && bus.s_cmd_ready;
    assign w_beat_hs    = bus.s_data_valid && bus.s_data_ready;
    assign w_final      = (r_beat_cnt == r_beats);
    assign w_last_chunk = (r_rem == r_chunk);

    // Handshake enables are combinational so they can be gated by rst.
    assign bus.s_cmd_ready   = !rst && (r_state == IDLE);
    assign bus.s_data_ready  = !rst && w_in_data && bus.m_data_ready;
    assign bus.m_data_valid  = !rst && w_in_data && bus.s_data_valid;
    assign bus.m_data_data   = bus.s_data_data;
    assign bus.m_data_keep   = bus.s_data_keep;
    assign bus.m_data_last   = w_in_data && w_final;
    assign bus.m_cmd_valid   = r_m_cmd_valid;
    assign bus.m_cmd_address = r_cur_addr;
    assign bus.m_cmd_length  = r_chunk;

    assign cmd_count   = r_cmd_count;
    assign chunk_count = r_chunk_count;
    assign err_cmd     = r_err_cmd;
    assign err_last    = r_err_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cur_addr    <= '0;
            r_rem         <= '0;
            r_chunk       <= '0;
            r_beats       <= '0;
            r_beat_cnt    <= '0;
            r_m_cmd_valid <= 1'b0;
            r_cmd_count   <= '0;
            r_chunk_count <= '0;
            r_err_cmd     <= 1'b0;
            r_err_last    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_cur_addr  <= {bus.s_cmd_address[63:6], 6'b0};
                        r_rem       <= {bus.s_cmd_length[31:6], 6'b0};
                        r_cmd_count <= r_cmd_count + 32'd1;
                        if (bus.s_cmd_address[5:0] != 6'd0 ||
                            bus.s_cmd_length[5:0] != 6'd0 ||
                            bus.s_cmd_length == 32'd0)
                            r_err_cmd <= 1'b1;
                        if (bus.s_cmd_length[31:6] != 26'd0)
                            r_state <= CALC;
                    end
                end
                CALC: begin
                    r_chunk       <= w_chunk;
                    r_beats       <= w_beats;
                    r_m_cmd_valid <= 1'b1;
                    r_state       <= CMD;
                end
                CMD: begin
                    if (bus.m_cmd_ready) begin
                        r_m_cmd_valid <= 1'b0;
                        r_chunk_count <= r_chunk_count + 32'd1;
                        r_beat_cnt    <= '0;
                        r_state       <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat_hs) begin
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                        // Input last must land exactly on the command's final beat.
                        if (bus.s_data_last != (w_final && w_last_chunk))
                            r_err_last <= 1'b1;
                        if (w_final) begin
                            r_cur_addr <= r_cur_addr + 64'(r_chunk);
                            r_rem      <= r_rem - r_chunk;
                            r_state    <= w_last_chunk ? IDLE : CALC;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dma_write_splitter.md
Name: dma_write_splitter

Overview:
- Sits directly downstream of the DMA write command/data generator and upstream of the host DMA write interface.
- Takes one write command (address, byte length) plus its 512-bit data stream.
- Re-issues the command as a sequence of chunk commands. Each chunk is no larger than MAX_PAYLOAD and never crosses a BOUNDARY-byte address boundary.
- Re-frames the data stream so that m_data_last marks the final beat of every chunk.

Parameters:
MAX_PAYLOAD, 512, maximum chunk size in bytes; power of two, 64..BOUNDARY
BOUNDARY, 4096, address boundary in bytes that no chunk may cross; power of two

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
s_cmd_valid  in  1  input command valid
s_cmd_ready  out  1  input command ready
s_cmd_address  in  64  input command start byte address
s_cmd_length  in  32  input command byte length
s_data_valid  in  1  input data beat valid
s_data_ready  out  1  input data beat ready
s_data_data  in  512  input data beat
s_data_keep  in  64  input byte enables
s_data_last  in  1  input end-of-command marker (checked only)
m_cmd_valid  out  1  chunk command valid
m_cmd_ready  in  1  chunk command ready
m_cmd_address  out  64  chunk start address
m_cmd_length  out  32  chunk byte length
m_data_valid  out  1  output beat valid
m_data_ready  in  1  output beat ready
m_data_data  out  512  output beat (pass-through)
m_data_keep  out  64  output byte enables (pass-through)
m_data_last  out  1  final beat of current chunk
cmd_count  out  32  input commands accepted
chunk_count  out  32  chunk commands issued
err_cmd  out  1  sticky: misaligned or zero-length command seen
err_last  out  1  sticky: s_data_last mismatched expected position

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, all counters 0, err flags 0, m_cmd_valid=0. While rst is high, s_cmd_ready, s_data_ready and m_data_valid are forced 0.
- A reset asserted mid-operation abandons the command. No partial chunk is completed.
- States: IDLE, CALC, CMD, DATA.
- IDLE:
  - s_cmd_ready=1.
  - On handshake: latch cur_addr = address with [5:0] cleared, and rem = length with [5:0] cleared.
  - Set err_cmd if address[5:0]!=0, length[5:0]!=0 or length==0.
  - Increment cmd_count.
  - If rem==0, stay IDLE: command dropped, no data consumed. Otherwise go to CALC.
- CALC:
  - One cycle. Register chunk = min(rem, MAX_PAYLOAD, BOUNDARY - (cur_addr mod BOUNDARY)).
  - Register beats = chunk/64 - 1. Go to CMD.
- CMD:
  - m_cmd_valid=1, m_cmd_address=cur_addr, m_cmd_length=chunk. Fields are stable while valid and not ready.
  - On handshake: increment chunk_count, load beat_cnt=0, go to DATA.
- DATA:
  - Zero-latency pass-through: m_data_valid = s_data_valid; s_data_ready = m_data_ready; data and keep are copied.
  - m_data_last = (beat_cnt==beats).
  - Each beat handshake increments beat_cnt.
  - On the final beat handshake: cur_addr += chunk, rem -= chunk. If rem==0 go to IDLE, else go to CALC.
- In all states other than DATA: s_data_ready=0 and m_data_valid=0. m_data_data and m_data_keep still follow the inputs.
- Latency:
  - Input command handshake at cycle T gives m_cmd_valid at T+2.
  - Between chunks there are 2 bubble cycles (CALC, CMD) minimum.
  - Final beat of the last chunk at cycle T gives s_cmd_ready at T+1.
- err_last:
  - Set if s_data_last=1 on any accepted beat other than the final beat of the final chunk.
  - Set if s_data_last=0 on that final beat.
  - Output framing is never altered by s_data_last.
- Arithmetic: cur_addr wraps modulo 2^64. cmd_count and chunk_count wrap modulo 2^32. Err flags clear only on reset.
- One command in flight at a time. No new command is accepted until the previous one's data is fully passed.

Test Plan:
- cmd (0x1000, 1024), MAX_PAYLOAD=512 -> m_cmd (0x1000,512) then (0x1200,512); 8 beats each; m_data_last on beats 8 and 16; chunk_count=2, no errs.
- cmd (0x1F80, 256) -> (0x1F80,128) then (0x2000,128); boundary at 0x2000 not crossed; 2+2 beats.
- cmd (0x0, 2048) with m_data_ready toggled 1/0 each cycle and m_cmd_ready delayed 5 cycles -> 4 chunks of 512; all 32 beats delivered in order with data equal to input; no duplication or loss.
- cmd (0x1010, 200) -> err_cmd=1; treated as (0x1000,192): one chunk of 3 beats. Then cmd length 0 -> cmd_count=2, no m_cmd_valid, s_data_ready stays 0.
- cmd (0x0, 512) with s_data_last on beat 3 -> err_last=1; m_data_last still only on beat 8.
- rst asserted in DATA after 4 of 8 beats -> next cycle m_cmd_valid=0, m_data_valid=0, counters and errs 0; after rst release s_cmd_ready=1 and a new cmd (0x0, 64) completes normally.
